cp0_regs_ext: RTL and testbench

Parametrised CP0 system-control block for the MIPS core. It holds Count, Compare, Status, Cause, EPC, PRId, Config and, optionally, BadVAddr. It adds the following:
- a configurable Count prescaler;
- a Cause.TI timer-interrupt flag;
- hardware exception entry and ERET handling;
- a masked interrupt request to the pipeline.

---
 rtl/cp0_regs_ext.sv | 189 ++++++++++++++++++
 tb/tb_cp0_regs_ext.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regs_ext.sv
// CP0 system-control registers: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Define CP0_BADVADDR_EN to implement BadVAddr (reg 8); otherwise reg 8 reads as zero.
module cp0_regs_ext #(
   parameter int unsigned COUNT_DIV  = 2,
   parameter int unsigned NUM_HW_INT = 6,
   parameter int unsigned TIMER_IP   = 7,
   parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [4:0]            raddr_i,
   input  logic [31:0]           data_i,
   output logic [31:0]           data_o,
   input  logic [NUM_HW_INT-1:0] int_i,
   input  logic                  exc_valid_i,
   input  logic [4:0]            exc_code_i,
   input  logic [31:0]           exc_pc_i,
   input  logic                  exc_bd_i,
   input  logic [31:0]           exc_badvaddr_i,
   input  logic                  eret_i,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  int_req_o,
   output logic [31:0]           exc_vector_o
);
   localparam logic [31:0] CONFIG_VAL = 32'h8000_0000;
   localparam logic [31:0] STATUS_RO  = 32'h1040_0000;
   localparam logic [3:0]  PRESC_MAX  = 4'(COUNT_DIV - 1);

   logic [31:0] count_q, count_d, compare_q, compare_d, epc_q, epc_d;
   logic [3:0]  presc_q, presc_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d;
   logic        bd_q, bd_d, ti_q, ti_d, iv_q, iv_d;
   logic [1:0]  swip_q, swip_d;
   logic [4:0]  code_q, code_d;
   logic [NUM_HW_INT-1:0] hwip_q;
   logic [7:0]  ip;
   logic [31:0] badvaddr_rd;
   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

   assign wr_count   = we_i && (waddr_i == 5'd9);
   assign wr_compare = we_i && (waddr_i == 5'd11);
   assign wr_status  = we_i && (waddr_i == 5'd12);
   assign wr_cause   = we_i && (waddr_i == 5'd13);
   assign wr_epc     = we_i && (waddr_i == 5'd14);

   // IP[7:2] = sampled hardware lines, with the timer flag folded into TIMER_IP.
   assign ip[1:0] = swip_q;
   genvar gi;
   for (gi = 0; gi < 6; gi++) begin : g_ip
      logic hw_bit;
      if (gi < NUM_HW_INT) begin : g_hw
         assign hw_bit = hwip_q[gi];
      end else begin : g_nohw
         assign hw_bit = 1'b0;
      end
      if (gi + 2 == TIMER_IP) begin : g_tmr
         assign ip[gi+2] = hw_bit | ti_q;
      end else begin : g_notmr
         assign ip[gi+2] = hw_bit;
      end
   end

   always_comb begin
      count_d   = count_q;
      presc_d   = presc_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      iv_d      = iv_q;
      swip_d    = swip_q;
      epc_d     = epc_q;
      bd_d      = bd_q;
      code_d    = code_q;

      if (wr_count) begin
         count_d = data_i;
         presc_d = '0;
      end else if (presc_q == PRESC_MAX) begin
         count_d = count_q + 32'd1;
         presc_d = '0;
      end else begin
         presc_d = presc_q + 4'd1;
      end

      if (wr_compare) begin
         compare_d = data_i;
         ti_d      = 1'b0;
      end else if ((count_q == compare_q) && (compare_q != '0)) begin
         ti_d = 1'b1;
      end

      if (wr_status) begin
         im_d  = data_i[15:8];
         exl_d = data_i[1];
         ie_d  = data_i[0];
      end
      if (wr_cause) begin
         iv_d   = data_i[23];
         swip_d = data_i[9:8];
      end
      if (wr_epc) epc_d = data_i;

      // Later assignments override earlier ones: exception > ERET > MTC0.
      if (eret_i) exl_d = 1'b0;
      if (exc_valid_i) begin
         if (!exl_q) begin
            epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
            bd_d  = exc_bd_i;
         end
         code_d = exc_code_i;
         exl_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         presc_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         iv_q      <= 1'b0;
         swip_q    <= '0;
         epc_q     <= '0;
         bd_q      <= 1'b0;
         code_q    <= '0;
         hwip_q    <= '0;
      end else begin
         count_q   <= count_d;
         presc_q   <= presc_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         iv_q      <= iv_d;
         swip_q    <= swip_d;
         epc_q     <= epc_d;
         bd_q      <= bd_d;
         code_q    <= code_d;
         hwip_q    <= int_i;
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         badvaddr_q <= '0;
      else if (exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)))
         badvaddr_q <= exc_badvaddr_i;
   end
   assign badvaddr_rd = badvaddr_q;
`else
   logic unused_badvaddr;
   assign unused_badvaddr = ^exc_badvaddr_i;
   assign badvaddr_rd     = '0;
`endif

   assign status_o     = STATUS_RO | {16'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_o      = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip, 1'b0, code_q, 2'b0};
   assign epc_o        = epc_q;
   assign int_req_o    = ie_q & ~exl_q & (|(ip & im_q));
   assign exc_vector_o = status_o[22] ? 32'hBFC0_0380 : 32'h8000_0180;

   always_comb begin
      data_o = '0;
      case (raddr_i)
         5'd8:    data_o = badvaddr_rd;
         5'd9:    data_o = count_q;
         5'd11:   data_o = compare_q;
         5'd12:   data_o = status_o;
         5'd13:   data_o = cause_o;
         5'd14:   data_o = epc_q;
         5'd15:   data_o = PRID_VAL;
         5'd16:   data_o = CONFIG_VAL;
         default: data_o = '0;
      endcase
   end
endmodule

// File: tb/tb_cp0_regs_ext.sv
// Randomised bench for cp0_regs_ext: a word-level model of the CP0 rules is checked
// against every output on every cycle, plus directed literal checks for the key scenarios.
module tb_cp0_regs_ext;
   localparam int          COUNT_DIV  = 2;
   localparam int          NUM_HW_INT = 6;
   localparam int          TIMER_IP   = 7;
   localparam logic [31:0] PRID_VAL   = 32'h0000_4220;
   localparam logic [31:0] CONFIG_VAL = 32'h8000_0000;
   localparam logic [31:0] ST_RESET   = 32'h1040_0000;
   localparam logic [31:0] ST_WMASK   = 32'h0000_FF03;
`ifdef CP0_BADVADDR_EN
   localparam bit BADV_EN = 1'b1;
`else
   localparam bit BADV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic we_i = 1'b0;
   logic [4:0] waddr_i = '0, raddr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic [NUM_HW_INT-1:0] int_i = '0;
   logic exc_valid_i = 1'b0;
   logic [4:0] exc_code_i = '0;
   logic [31:0] exc_pc_i = '0;
   logic exc_bd_i = 1'b0;
   logic [31:0] exc_badvaddr_i = '0;
   logic eret_i = 1'b0;
   logic [31:0] status_o, cause_o, epc_o, exc_vector_o;
   logic int_req_o;

   always #5 clk = ~clk;

   cp0_regs_ext #(
      .COUNT_DIV(COUNT_DIV), .NUM_HW_INT(NUM_HW_INT), .TIMER_IP(TIMER_IP), .PRID_VAL(PRID_VAL)
   ) dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
      .data_i(data_i), .data_o(data_o), .int_i(int_i), .exc_valid_i(exc_valid_i),
      .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
      .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .status_o(status_o),
      .cause_o(cause_o), .epc_o(epc_o), .int_req_o(int_req_o), .exc_vector_o(exc_vector_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_count, m_compare, m_status, m_epc, m_badv;
   int          m_tick;
   logic        m_bd, m_ti, m_iv;
   logic [1:0]  m_swip;
   logic [5:0]  m_hw;
   logic [4:0]  m_code;

   function automatic logic [7:0] m_ip();
      logic [7:0] ip;
      ip = {m_hw, m_swip};
      ip[TIMER_IP] = ip[TIMER_IP] | m_ti;
      return ip;
   endfunction

   function automatic logic [31:0] m_cause();
      return {m_bd, m_ti, 6'b0, m_iv, 7'b0, m_ip(), 1'b0, m_code, 2'b0};
   endfunction

   function automatic logic m_intreq();
      return m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'h00);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return BADV_EN ? m_badv : 32'h0;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         5'd15:   return PRID_VAL;
         5'd16:   return CONFIG_VAL;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_count = 0; m_compare = 0; m_status = ST_RESET; m_epc = 0; m_badv = 0;
      m_tick = 0; m_bd = 0; m_ti = 0; m_iv = 0; m_swip = 0; m_hw = 0; m_code = 0;
   endtask

   task automatic model_step();
      logic [31:0] n_count, n_compare, n_status, n_epc, n_badv;
      int          n_tick;
      logic        n_bd, n_ti, n_iv;
      logic [1:0]  n_swip;
      n_count = m_count; n_compare = m_compare; n_status = m_status; n_epc = m_epc;
      n_badv = m_badv; n_tick = m_tick; n_bd = m_bd; n_ti = m_ti; n_iv = m_iv; n_swip = m_swip;

      if (we_i && waddr_i == 5'd9) begin
         n_count = data_i; n_tick = 0;
      end else if (m_tick == COUNT_DIV - 1) begin
         n_count = m_count + 1; n_tick = 0;
      end else begin
         n_tick = m_tick + 1;
      end
      if (we_i && waddr_i == 5'd11) begin
         n_compare = data_i; n_ti = 0;
      end else if (m_compare != 0 && m_count == m_compare) begin
         n_ti = 1;
      end
      if (we_i && waddr_i == 5'd12) n_status = (m_status & ~ST_WMASK) | (data_i & ST_WMASK);
      if (we_i && waddr_i == 5'd13) begin n_iv = data_i[23]; n_swip = data_i[9:8]; end
      if (we_i && waddr_i == 5'd14) n_epc = data_i;
      if (eret_i) n_status[1] = 1'b0;
      if (exc_valid_i) begin
         if (!m_status[1]) begin
            n_epc = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
            n_bd  = exc_bd_i;
         end
         m_code = exc_code_i;
         n_status[1] = 1'b1;
         if (exc_code_i == 5'd4 || exc_code_i == 5'd5) n_badv = exc_badvaddr_i;
      end
      m_hw = 6'(int_i);
      m_count = n_count; m_compare = n_compare; m_status = n_status; m_epc = n_epc;
      m_badv = n_badv; m_tick = n_tick; m_bd = n_bd; m_ti = n_ti; m_iv = n_iv; m_swip = n_swip;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("status_o", status_o, m_status);
         chk("cause_o", cause_o, m_cause());
         chk("epc_o", epc_o, m_epc);
         chk("int_req_o", 32'(int_req_o), 32'(m_intreq()));
         chk("exc_vector_o", exc_vector_o, m_status[22] ? 32'hBFC0_0380 : 32'h8000_0180);
         chk($sformatf("data_o[r%0d]", raddr_i), data_o, m_read(raddr_i));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
      tick();
      we_i = 1'b0;
   endtask

   task automatic chk_reset_literals(input string tag);
      chk({tag, "_status"}, status_o, 32'h1040_0000);
      chk({tag, "_cause"}, cause_o, 32'h0);
      chk({tag, "_epc"}, epc_o, 32'h0);
      chk({tag, "_intreq"}, 32'(int_req_o), 32'h0);
      chk({tag, "_vector"}, exc_vector_o, 32'hBFC0_0380);
   endtask

   logic [31:0] d;

   initial begin
      repeat (3) tick();
      raddr_i = 5'd9;
      chk_reset_literals("rst0");
      chk("rst0_count", data_o, 32'h0);
      rst = 1'b0;

      repeat (10) tick();
      chk("count_after_10", data_o, 32'd5);
      wr(5'd9, 32'hFFFF_FFFF);
      chk("count_loaded", data_o, 32'hFFFF_FFFF);
      tick(); tick();
      chk("count_wrap", data_o, 32'h0);

      // Timer
      wr(5'd12, 32'h1000_8001);
      chk("status_im7_ie", status_o, 32'h1040_8001);
      wr(5'd11, 32'd20);
      wr(5'd9, 32'd20);
      chk("ti_before_match", cause_o, 32'h0);
      tick();
      chk("ti_after_match", cause_o, 32'h4000_8000);
      chk("intreq_timer", 32'(int_req_o), 32'h1);
      wr(5'd11, 32'd50);
      chk("ti_cleared", cause_o, 32'h0);
      chk("intreq_timer_off", 32'(int_req_o), 32'h0);
      wr(5'd9, 32'd50);
      wr(5'd11, 32'd77);
      chk("ti_clear_wins", cause_o[30], 1'b0);
      tick();
      chk("ti_clear_wins2", cause_o[30], 1'b0);

      // Hardware interrupt
      int_i = 6'h01;
      wr(5'd12, 32'h0000_0401);
      chk("intreq_hw", 32'(int_req_o), 32'h1);
      wr(5'd12, 32'h0000_0403);
      chk("intreq_exl_mask", 32'(int_req_o), 32'h0);
      int_i = '0;
      wr(5'd12, 32'h0);
      chk("status_cleared", status_o, 32'h1040_0000);

      // Exception entry and nesting
      raddr_i = 5'd8;
      exc_valid_i = 1'b1; exc_code_i = 5'h04; exc_pc_i = 32'h8000_1004;
      exc_bd_i = 1'b1; exc_badvaddr_i = 32'h0000_0003;
      tick();
      exc_valid_i = 1'b0;
      chk("exc_epc", epc_o, 32'h8000_1000);
      chk("exc_cause", cause_o, 32'h8000_0010);
      chk("exc_exl", status_o, 32'h1040_0002);
      chk("exc_badvaddr", data_o, BADV_EN ? 32'h3 : 32'h0);
      exc_valid_i = 1'b1; exc_code_i = 5'h0C; exc_pc_i = 32'h8000_2000; exc_bd_i = 1'b0;
      tick();
      exc_valid_i = 1'b0;
      chk("nested_epc", epc_o, 32'h8000_1000);
      chk("nested_cause", cause_o, 32'h8000_0030);

      // Priority
      eret_i = 1'b1;
      wr(5'd12, 32'h0000_0003);
      eret_i = 1'b0;
      chk("eret_over_mtc0", status_o, 32'h1040_0001);
      exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'h00; exc_pc_i = 32'h8000_3000;
      tick();
      exc_valid_i = 1'b0; eret_i = 1'b0;
      chk("exc_over_eret", status_o, 32'h1040_0003);
      chk("exc_over_eret_epc", epc_o, 32'h8000_3000);

      // Randomised phase, with one asynchronous reset mid-run
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #1 rst = 1'b1;
            #1;
            chk_reset_literals("rst_mid");
            tick(); tick();
            rst = 1'b0;
         end
         we_i = ($urandom_range(3) == 0);
         case ($urandom_range(9))
            0:       waddr_i = 5'd9;
            1:       waddr_i = 5'd11;
            2, 3:    waddr_i = 5'd12;
            4:       waddr_i = 5'd13;
            5:       waddr_i = 5'd14;
            6:       waddr_i = 5'd8;
            7:       waddr_i = 5'd15;
            8:       waddr_i = 5'd16;
            default: waddr_i = 5'($urandom_range(31));
         endcase
         d = $urandom;
         if (waddr_i == 5'd11 && $urandom_range(1) == 1) d = m_count + $urandom_range(6);
         if (waddr_i == 5'd9 && $urandom_range(1) == 1) d = m_compare - $urandom_range(6);
         if (waddr_i == 5'd12 && $urandom_range(1) == 1) d[1] = 1'b0;
         data_i = d;
         raddr_i = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(8, 16));
         if ($urandom_range(7) == 0) int_i = 6'($urandom);
         exc_valid_i = ($urandom_range(15) == 0);
         exc_code_i = ($urandom_range(1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
         exc_pc_i = $urandom;
         exc_bd_i = 1'($urandom);
         exc_badvaddr_i = $urandom;
         eret_i = ($urandom_range(11) == 0);
         tick();
      end
      we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
